// File: rtl/one_hot_encoder_reg.sv
// rtl/one_hot_encoder_reg.sv - registered one-hot to {cod, enable} encoder with multi-hot error tracking
//
// Turns WIDTH one-hot select lines back into an encoded index plus an enable
// flag, held in a single-entry valid/ready buffered stage. Multi-hot words
// are flagged with a sticky error bit and counted in a saturating counter.
//
// Optional feature macro: ONE_HOT_ENC_PRIORITY_EN
//   defined     : multi-hot words resolve to the lowest set index, enable=1
//   not defined : multi-hot words give cod=0, enable=0
//   err/err_cnt behave the same in both builds.
//
// Parameters:
//   WIDTH      number of one-hot lines, power of 2, 2..8
//   ERR_CNT_W  width of the saturating multi-hot counter
//   CODE_W     log2(WIDTH), derived, not overridable
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   onehot word present
//   in_ready   stage can accept a word this cycle (combinational)
//   onehot     select lines, bit0 = line a
//   out_valid  {cod, enable} holds a word
//   out_ready  consumer accepts the word this cycle
//   cod        encoded index
//   enable     1 = a single line (or priority-resolved line) was set
//   err        sticky multi-hot flag
//   err_cnt    saturating count of accepted multi-hot words
//   clear_err  synchronous clear of err and err_cnt

module one_hot_encoder_reg #(
    parameter  int WIDTH     = 8,
    parameter  int ERR_CNT_W = 8,
    localparam int CODE_W    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     onehot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CODE_W-1:0]    cod,
    output logic                 enable,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clear_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;

    logic              accept;
    logic              any_hot;
    logic              multi_hot;
    logic [CODE_W-1:0] low_idx;
    logic [CODE_W-1:0] enc_cod;
    logic              enc_en;
    logic              cnt_sat;

    // Pass-through ready: a full stage can take a new word in the same
    // cycle its current word is consumed.
    assign in_ready = (state == EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

    // x & (x-1) clears the lowest set bit; anything left means two or more
    // lines were set.
    assign any_hot   = |onehot;
    assign multi_hot = |(onehot & (onehot - WIDTH'(1)));

    // Scan from the top so the last hit is the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                low_idx = CODE_W'(i);
            end
        end
    end

`ifdef ONE_HOT_ENC_PRIORITY_EN
    always_comb begin
        enc_en  = any_hot;
        enc_cod = low_idx;
    end
`else
    always_comb begin
        enc_en  = any_hot & ~multi_hot;
        enc_cod = enc_en ? low_idx : '0;
    end
`endif

    assign cnt_sat = &err_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            cod       <= '0;
            enable    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        cod       <= enc_cod;
                        enable    <= enc_en;
                    end
                end
                FULL: begin
                    // Without out_ready the word is held and onehot ignored.
                    if (out_ready) begin
                        if (in_valid) begin
                            cod    <= enc_cod;
                            enable <= enc_en;
                        end else begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase

            // A clear coinciding with a new multi-hot word is applied first,
            // so the new error lands on a zeroed counter.
            if (accept && multi_hot) begin
                err <= 1'b1;
                if (clear_err) begin
                    err_cnt <= ERR_CNT_W'(1);
                end else if (!cnt_sat) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (clear_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_one_hot_encoder_reg.sv
// tb/tb_one_hot_encoder_reg.sv - scoreboard bench for one_hot_encoder_reg

module tb_one_hot_encoder_reg;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] onehot;
    logic       out_ready;
    logic       clear_err;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [2:0] cod,       cod2;
    logic       enable,    enable2;
    logic       err,       err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    one_hot_encoder_reg #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .onehot(onehot), .out_valid(out_valid), .out_ready(out_ready),
        .cod(cod), .enable(enable), .err(err), .err_cnt(err_cnt),
        .clear_err(clear_err)
    );

    one_hot_encoder_reg #(.WIDTH(8), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .onehot(onehot), .out_valid(out_valid2), .out_ready(out_ready),
        .cod(cod2), .enable(enable2), .err(err2), .err_cnt(err_cnt2),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [2:0] cod;
        logic       en;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic       m_full = 1'b0;
    logic       m_err  = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;
    int         popped = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] w);
        exp_t r;
        int   n;
        n     = $countones(w);
        r.word = w;
        r.cod  = 3'd0;
        r.en   = 1'b0;
        if (n == 1) begin
            for (int i = 0; i < 8; i++) begin
                if (w == (8'b1 << i)) begin
                    r.cod = 3'(i);
                    r.en  = 1'b1;
                end
            end
        end
`ifdef ONE_HOT_ENC_PRIORITY_EN
        else if (n >= 2) begin
            for (int i = 7; i >= 0; i--) begin
                if (w[i]) r.cod = 3'(i);
            end
            r.en = 1'b1;
        end
`endif
        return r;
    endfunction

    // One clock cycle: drive inputs, score any consumed word, push any
    // accepted word, then check registered state after the edge.
    task automatic step(input logic iv, input logic [7:0] oh, input logic ordy, input logic clr);
        logic acc;
        logic multi;
        exp_t e;
        logic [7:0] dec;
        in_valid  = iv;
        onehot    = oh;
        out_ready = ordy;
        clear_err = clr;
        #1;
        acc   = iv & in_ready;
        multi = ($countones(oh) >= 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, ~m_full | ordy});
        if (out_valid && ordy) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL sb_underflow observed=%0d expected=%0d", 0, 1);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                popped++;
                check("cod", {29'd0, cod}, {29'd0, e.cod});
                check("enable", {31'd0, enable}, {31'd0, e.en});
                if ($countones(e.word) <= 1) begin
                    dec = enable ? (8'b1 << cod) : 8'h00;
                    check("roundtrip", {24'd0, dec}, {24'd0, e.word});
                end
            end
        end
        if (acc) sb.push_back(model(oh));
        @(posedge clk);
        #1;
        if (acc) m_full = 1'b1;
        else if (ordy) m_full = 1'b0;
        if (acc && multi) begin
            m_err  = 1'b1;
            m_cnt8 = clr ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
            m_cnt2 = clr ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
        end else if (clr) begin
            m_err  = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("err_cnt", {24'd0, err_cnt}, 32'(m_cnt8));
        check("err2", {31'd0, err2}, {31'd0, m_err});
        check("err_cnt2", {30'd0, err_cnt2}, 32'(m_cnt2));
    endtask

    function automatic logic [7:0] rand_multi();
        int a;
        int b;
        a = $urandom_range(0, 7);
        b = (a + 1 + $urandom_range(0, 6)) % 8;
        return (8'b1 << a) | (8'b1 << b);
    endfunction

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        onehot    = 8'h00;
        out_ready = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cod", {29'd0, cod}, 32'd0);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b1;

        // reset while holding a word
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check("pre_rst_enable", {31'd0, enable}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_cod", {29'd0, cod}, 32'd0);
        check("mid_rst_enable", {31'd0, enable}, 32'd0);
        sb.delete();
        m_full = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // full-rate sweep of single-hot words
        popped = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'b1 << i, 1'b1, 1'b0);
        step(1'b0, 8'hxx, 1'b1, 1'b0);
        check("sweep_count", 32'(popped), 32'd8);

        // backpressure hold
        step(1'b1, 8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h01, 1'b0, 1'b0);
            check("bp_cod", {29'd0, cod}, 32'd5);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b0, 8'hxx, 1'b1, 1'b0);

        // idle word, then multi-hot words
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b0);
        step(1'b1, 8'h0C, 1'b1, 1'b0);
        step(1'b0, 8'hxx, 1'b1, 1'b0);

        // rejected multi-hot word must not count
        step(1'b1, 8'h02, 1'b1, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'hxx, 1'b1, 1'b0);

        // counter saturation and clear-with-error
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, rand_multi(), 1'b1, 1'b0);
        check("sat_cnt2", {30'd0, err_cnt2}, 32'd3);
        step(1'b1, rand_multi(), 1'b1, 1'b1);
        check("clr_err_cnt", {24'd0, err_cnt}, 32'd1);
        step(1'b0, 8'hxx, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // decoder round-trip over every legal word
        for (int i = 0; i < 8; i++) step(1'b1, 8'b1 << i, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'hxx, 1'b1, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
